// File: rtl/timer_sched.sv
`default_nettype none
// ============================================================================
// Module  : timer_sched
// Brief   : Round-robin scheduler sharing one down-counting delay timer among
//           NREQ requesters. Optional macro TIMER_SCHED_ABORT_EN lets the
//           granted requester cancel its job by dropping req while running.
// Revision: 1.0 - initial release
// ============================================================================
module timer_sched #(
    parameter int NREQ = 4,
    parameter int DBIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DBIT-1:0] dly,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [DBIT-1:0]      remain
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]         r_state,  w_state;
    logic [c_PTR_W-1:0] r_ptr,    w_ptr;
    logic [c_PTR_W-1:0] r_win,    w_win;
    logic [NREQ-1:0]    r_gnt,    w_gnt;
    logic [NREQ-1:0]    r_done,   w_done;
    logic               r_busy,   w_busy;
    logic [DBIT-1:0]    r_remain, w_remain;

    logic               w_found;
    logic [c_PTR_W-1:0] w_pick;
    logic [DBIT-1:0]    w_sel_dly;

    function automatic int rr_idx(input logic [c_PTR_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        return (s >= NREQ) ? s - NREQ : s;
    endfunction

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] w);
        return (int'(w) == NREQ - 1) ? '0 : w + 1'b1;
    endfunction

    // Scanning from the farthest offset down lets the offset closest to the
    // pointer overwrite the others, so it ends up as the winner.
    always_comb begin : p_arb
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[rr_idx(r_ptr, i)]) begin
                w_found = 1'b1;
                w_pick  = c_PTR_W'(rr_idx(r_ptr, i));
            end
        end
        w_sel_dly = dly[int'(w_pick)*DBIT +: DBIT];
    end

    always_comb begin : p_next
        w_state  = r_state;
        w_ptr    = r_ptr;
        w_win    = r_win;
        w_gnt    = r_gnt;
        w_done   = '0;
        w_busy   = r_busy;
        w_remain = r_remain;
        case (r_state)
            c_S_IDLE: begin
                if (w_found) begin
                    w_state  = c_S_RUN;
                    w_win    = w_pick;
                    w_gnt    = NREQ'(1) << w_pick;
                    w_busy   = 1'b1;
                    w_remain = (w_sel_dly == '0) ? DBIT'(1) : w_sel_dly;
                end
            end
            c_S_RUN: begin
`ifdef TIMER_SCHED_ABORT_EN
                if (!req[r_win]) begin
                    w_state  = c_S_IDLE;
                    w_gnt    = '0;
                    w_busy   = 1'b0;
                    w_remain = '0;
                    w_ptr    = next_ptr(r_win);
                end else
`endif
                if (r_remain > DBIT'(1)) begin
                    w_remain = r_remain - 1'b1;
                end else begin
                    w_remain = '0;
                    w_done   = r_gnt;
                    w_state  = c_S_DONE;
                end
            end
            c_S_DONE: begin
                w_state = c_S_IDLE;
                w_gnt   = '0;
                w_busy  = 1'b0;
                w_ptr   = next_ptr(r_win);
            end
            default: begin
                w_state  = c_S_IDLE;
                w_gnt    = '0;
                w_busy   = 1'b0;
                w_remain = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin : p_regs
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_ptr    <= '0;
            r_win    <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
            r_remain <= '0;
        end else begin
            r_state  <= w_state;
            r_ptr    <= w_ptr;
            r_win    <= w_win;
            r_gnt    <= w_gnt;
            r_done   <= w_done;
            r_busy   <= w_busy;
            r_remain <= w_remain;
        end
    end

    assign gnt    = r_gnt;
    assign done   = r_done;
    assign busy   = r_busy;
    assign remain = r_remain;

endmodule
`default_nettype wire

// File: tb/tb_timer_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_timer_sched
// Brief   : Directed vector bench for timer_sched (NREQ=4, DBIT=16).
// Revision: 1.0 - initial release
// ============================================================================
module tb_timer_sched;

    localparam int NREQ = 4;
    localparam int DBIT = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*DBIT-1:0] dly;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 busy;
    logic [DBIT-1:0]      remain;

    int n_checks = 0;
    int n_errors = 0;

    timer_sched #(.NREQ(NREQ), .DBIT(DBIT)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .dly    (dly),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .remain (remain)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [63:0] dly;
        logic [3:0]  gnt;
        logic [3:0]  done;
        logic        busy;
        logic [15:0] remain;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [63:0] d,
                                input logic [3:0] eg, input logic [3:0] ed,
                                input logic eb, input logic [15:0] er);
        vec_t v;
        v.rst = r; v.req = q; v.dly = d;
        v.gnt = eg; v.done = ed; v.busy = eb; v.remain = er;
        return v;
    endfunction

    // Inputs are sampled at the next rising edge; outputs are checked 1 ns later.
    task automatic step(input logic r, input logic [3:0] q, input logic [63:0] d,
                        input logic [3:0] eg, input logic [3:0] ed,
                        input logic eb, input logic [15:0] er, input string nm);
        rst = r; req = q; dly = d;
        @(posedge clk);
        #1;
        n_checks++;
        if (gnt !== eg || done !== ed || busy !== eb || remain !== er) begin
            n_errors++;
            $display("FAIL %s: got gnt=%b done=%b busy=%b remain=%0d, expected gnt=%b done=%b busy=%b remain=%0d",
                     nm, gnt, done, busy, remain, eg, ed, eb, er);
        end
    endtask

    localparam logic [63:0] D_RR  = 64'h0002_0002_0002_0002;
    localparam logic [63:0] D_ONE = 64'h0000_0005_0000_0000;
    localparam logic [63:0] D_MID = 64'h0000_0000_0000_000A;
    localparam logic [63:0] D_R3  = 64'h0001_0000_0000_0000;
    localparam logic [63:0] D_ABT = 64'h0000_0006_0000_0000;

    initial begin
        rst = 1'b1; req = '0; dly = '0;

        // Reset with all requests high
        vecs.push_back(mk(1, 4'b1111, D_RR, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(1, 4'b1111, D_RR, 4'b0000, 4'b0000, 0, 0));
        // Round robin 0,1,2,3 then re-raised 0
        vecs.push_back(mk(0, 4'b1111, D_RR, 4'b0001, 4'b0000, 1, 2));
        vecs.push_back(mk(0, 4'b1111, D_RR, 4'b0001, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 4'b1111, D_RR, 4'b0001, 4'b0001, 1, 0));
        vecs.push_back(mk(0, 4'b1110, D_RR, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b1110, D_RR, 4'b0010, 4'b0000, 1, 2));
        vecs.push_back(mk(0, 4'b1110, D_RR, 4'b0010, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 4'b1110, D_RR, 4'b0010, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 4'b1100, D_RR, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b1101, D_RR, 4'b0100, 4'b0000, 1, 2));
        vecs.push_back(mk(0, 4'b1101, D_RR, 4'b0100, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 4'b1101, D_RR, 4'b0100, 4'b0100, 1, 0));
        vecs.push_back(mk(0, 4'b1001, D_RR, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b1001, D_RR, 4'b1000, 4'b0000, 1, 2));
        vecs.push_back(mk(0, 4'b1001, D_RR, 4'b1000, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 4'b1001, D_RR, 4'b1000, 4'b1000, 1, 0));
        vecs.push_back(mk(0, 4'b0001, D_RR, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0001, D_RR, 4'b0001, 4'b0000, 1, 2));
        vecs.push_back(mk(0, 4'b0001, D_RR, 4'b0001, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 4'b0001, D_RR, 4'b0001, 4'b0001, 1, 0));
        vecs.push_back(mk(0, 4'b0000, D_RR, 4'b0000, 4'b0000, 0, 0));
        // Single job, requester 2, delay 5 (pointer is 1 here)
        vecs.push_back(mk(0, 4'b0100, D_ONE, 4'b0100, 4'b0000, 1, 5));
        vecs.push_back(mk(0, 4'b0100, D_ONE, 4'b0100, 4'b0000, 1, 4));
        vecs.push_back(mk(0, 4'b0100, D_ONE, 4'b0100, 4'b0000, 1, 3));
        vecs.push_back(mk(0, 4'b0100, D_ONE, 4'b0100, 4'b0000, 1, 2));
        vecs.push_back(mk(0, 4'b0100, D_ONE, 4'b0100, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 4'b0100, D_ONE, 4'b0100, 4'b0100, 1, 0));
        vecs.push_back(mk(0, 4'b0000, D_ONE, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0000, D_ONE, 4'b0000, 4'b0000, 0, 0));
        // Zero delay on requester 1 behaves as delay 1
        vecs.push_back(mk(0, 4'b0010, 64'h0, 4'b0010, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 4'b0010, 64'h0, 4'b0010, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 64'h0, 4'b0000, 4'b0000, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].dly, vecs[i].gnt, vecs[i].done,
                 vecs[i].busy, vecs[i].remain, $sformatf("vec%0d", i));
        end

        // Mid-run reset: requester 0 with delay 10, reset at remain=4
        step(0, 4'b0001, D_MID, 4'b0001, 4'b0000, 1, 10, "mid_load");
        for (int k = 9; k >= 4; k--) begin
            step(0, 4'b0001, D_MID, 4'b0001, 4'b0000, 1, 16'(k), $sformatf("mid_run%0d", k));
        end
        step(1, 4'b0000, D_MID, 4'b0000, 4'b0000, 0, 0, "mid_rst");
        step(0, 4'b1000, D_R3, 4'b1000, 4'b0000, 1, 1, "mid_r3_gnt");
        step(0, 4'b1000, D_R3, 4'b1000, 4'b1000, 1, 0, "mid_r3_done");
        step(0, 4'b0000, D_R3, 4'b0000, 4'b0000, 0, 0, "mid_idle");

        // Requester 2 drops req at remain=3 while 0 and 3 wait; pointer is 0 here
        step(0, 4'b0100, D_ABT, 4'b0100, 4'b0000, 1, 6, "abt_load");
        step(0, 4'b1101, D_ABT, 4'b0100, 4'b0000, 1, 5, "abt_run5");
        step(0, 4'b1101, D_ABT, 4'b0100, 4'b0000, 1, 4, "abt_run4");
        step(0, 4'b1101, D_ABT, 4'b0100, 4'b0000, 1, 3, "abt_run3");
`ifdef TIMER_SCHED_ABORT_EN
        step(0, 4'b1001, D_ABT, 4'b0000, 4'b0000, 0, 0, "abt_cancel");
`else
        step(0, 4'b1001, D_ABT, 4'b0100, 4'b0000, 1, 2, "abt_run2");
        step(0, 4'b1001, D_ABT, 4'b0100, 4'b0000, 1, 1, "abt_run1");
        step(0, 4'b1001, D_ABT, 4'b0100, 4'b0100, 1, 0, "abt_done");
        step(0, 4'b1001, D_ABT, 4'b0000, 4'b0000, 0, 0, "abt_idle");
`endif
        step(0, 4'b1001, D_ABT, 4'b1000, 4'b0000, 1, 1, "abt_r3_gnt");
        step(0, 4'b1001, D_ABT, 4'b1000, 4'b1000, 1, 0, "abt_r3_done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
